// File: rtl/rr_sel_arbiter_4.sv
// Round-robin select generator for a 4:1 mux: registered binary select plus one-hot grant,
// with release on done, request drop, or a max-hold timeout.
module rr_sel_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] req_in,
  input  logic       done_in,
  output logic [1:0] sel_out,
  output logic [3:0] gnt_out,
  output logic       valid_out,
  output logic       dbg_state
);

  // Handshake: a requester holds req_in[i] high until it sees gnt_out[i]; it keeps the grant
  // while req_in[i] stays high and done_in stays low. Releasing (done_in or dropping req_in[i])
  // takes effect on the next rising edge, where the next owner is selected without a bubble.

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       sel_n;
  logic [3:0]       gnt_n;
  logic             valid_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       search_base;
  logic [1:0]       cand;
  logic [1:0]       win_idx;
  logic             win_any;
  logic             release_now;

  // On release the outgoing owner becomes the new pointer, so search from it directly.
  assign search_base = (state == GRANT) ? sel_out : ptr;
  assign release_now = done_in | ~req_in[sel_out] | (cnt == HOLD_LAST);
  assign dbg_state   = (state == GRANT);

  // Scan from the farthest offset down so the closest requester after the base wins.
  always_comb begin
    win_any = 1'b0;
    win_idx = search_base;
    cand    = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = search_base + 2'(k);
      if (req_in[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel_out;
    gnt_n   = gnt_out;
    valid_n = valid_out;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_n = GRANT;
          sel_n   = win_idx;
          gnt_n   = 4'b0001 << win_idx;
          valid_n = 1'b1;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!release_now) begin
          cnt_n = cnt + CNT_W'(1);
        end else begin
          ptr_n = sel_out;
          cnt_n = '0;
          if (win_any) begin
            sel_n = win_idx;
            gnt_n = 4'b0001 << win_idx;
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            valid_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      ptr       <= 2'd3;
      sel_out   <= 2'd0;
      gnt_out   <= 4'b0000;
      valid_out <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel_out   <= sel_n;
      gnt_out   <= gnt_n;
      valid_out <= valid_n;
      cnt       <= cnt_n;
    end
  end

endmodule
